cfpu_pipe: RTL and testbench
============================

Name: cfpu_pipe

Overview:
- Parametrised, pipelined successor of the approximate FP multiplier (cfpu).
- Multiplies two IEEE-754-style operands of configurable exponent/mantissa width.
- Per-transaction mode selects exact RNE multiplication, or the approximate path: when one operand's mantissa is all-zero or all-ones, the mantissa multiplier is bypassed.
- Valid/ready streaming interface with backpressure, IEEE special-value handling and a saturating counter of approximate-path hits; sits between the operand scheduler and the result writeback.

Parameters:
E, 8, exponent width.
MA, 23, stored mantissa width (hidden bit excluded).
CNT_W, 32, approximate-hit counter width.
(derived: N = 1+E+MA; BIAS = 2^(E-1)-1)

Ports:
clk  in  1  clock; all state rising-edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept this cycle.
in_a  in  N  operand A {sign, exp, mant}.
in_b  in  N  operand B.
in_mode  in  1  0 = exact RNE, 1 = approximate allowed.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_y  out  N  product.
out_approx  out  1  result produced by the bypass path.
cnt_clr  in  1  synchronous clear of approx_cnt.
approx_cnt  out  CNT_W  number of approximate-path results delivered.

Behaviour:
- Reset (rst_n=0, async): all stage valids, out_valid, out_y, out_approx and approx_cnt go to 0. In-flight operations are discarded. in_ready=1 from the first cycle after release.
- Pipeline: 3 register stages.
  - S1: classify and mantissa product.
  - S2: normalise and round.
  - S3: exponent, special cases, pack.
  - Accept happens when in_valid & in_ready. The result appears with out_valid=1 exactly 3 cycles after accept, absent stalls. Throughput is 1 per cycle.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - During a stall all stages hold and outputs stay stable. Bubbles are not compressed.
  - out_valid drops only after a handshake with no new result behind it.
- Classification:
  - exp==0 → zero (denormals flushed).
  - exp all-ones with mant==0 → inf.
  - exp all-ones with mant!=0 → NaN.
- Special-value priority: NaN, then inf×zero → canonical qNaN {0, all-ones exp, 1, zeros}; else inf operand → signed inf; else zero operand → signed zero. Sign is always sa^sb, except for the qNaN.
- Exact path:
  - p = {1,ma}×{1,mb}, 2(MA+1) bits.
  - If the top bit is set, norm=1; otherwise shift left 1.
  - Guard = bit below kept MA bits; R = next bit; S = OR of the rest.
  - Round up iff G & (R | S | lsb), i.e. true round-to-nearest-even.
  - Mantissa carry-out → mantissa 0, exponent +1.
- Approximate path (in_mode=1, both operands normal finite):
  - If ma is all-zero or all-ones, A is the selector; else if mb is, B is the selector; else the exact path is used.
  - Result mantissa = the other operand's mantissa.
  - Exponent = ea+eb-BIAS, plus 1 if the selector mantissa is all-ones.
  - out_approx=1 only for results taken from this path.
  - in_mode=0 never sets out_approx.
- Exponent arithmetic: signed, E+2 bits.
  - Result ≥ 2^E-1 → signed inf (exp all-ones, mant 0).
  - Result ≤ 0 → signed zero.
  - Same rules apply to the approximate path.
- Counter:
  - approx_cnt increments on each out_valid & out_ready & out_approx handshake.
  - It saturates at all-ones, no wrap.
  - cnt_clr has priority over an increment in the same cycle.

Test Plan:
- 1.5×1.5 exact: in_a=0x3FC00000, in_b=0x3FC00000, mode=0 → out_y=0x40100000, out_approx=0, out_valid 3 cycles after accept.
- Bypass: in_a=0x3FFFFFFF, in_b=0x3FC00000.
  - mode=1 → 0x40400000, out_approx=1, approx_cnt +1.
  - mode=0 → 0x403FFFFF, out_approx=0.
- Overflow/underflow/NaN:
  - 0x7F000000×0x40000000 → 0x7F800000.
  - 0x00800000×0x3F000000 → 0x00000000.
  - 0x7F800000×0x00000000 → 0x7FC00000.
  - 0xBF800000×0x40000000 → 0xC0000000.
- Backpressure: stream 8 back-to-back ops with out_ready toggled randomly (held low 4 cycles) → in-order results, none lost or duplicated, out_y stable while stalled, in_ready=0 during the stall.
- Counter: CNT_W=4, 20 approximate ops → approx_cnt saturates at 0xF. cnt_clr asserted with a concurrent approx handshake → 0.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight → out_valid=0 immediately (async). No stale result after release; the next op completes normally.

Source files
------------

// File: rtl/cfpu_pipe.sv
// Pipelined IEEE-754-style multiplier with exact RNE and an approximate bypass path.
// Three register stages: classify/multiply, normalise/round, exponent/special/pack.
module cfpu_pipe #(
  parameter int unsigned E     = 8,
  parameter int unsigned MA    = 23,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E+MA:0]    in_a,
  input  logic [E+MA:0]    in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+MA:0]    out_y,
  output logic             out_approx,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int unsigned N    = 1 + E + MA;
  localparam int unsigned MW   = MA + 1;
  localparam int unsigned PW   = 2 * MW;
  localparam int unsigned XW   = E + 2;
  localparam int unsigned BIAS = (1 << (E - 1)) - 1;
  localparam int unsigned EMAX = (1 << E) - 1;

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_e;

  logic stall, en;
  assign stall    = out_valid_q & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  // Stage 1: classify operands, bias-adjusted exponent sum, full mantissa product
  logic          sa, sb;
  logic [E-1:0]  ea, eb;
  logic [MA-1:0] ma, mb;
  assign {sa, ea, ma} = in_a;
  assign {sb, eb, mb} = in_b;

  logic          za, zb, ia, ib, na, nb, sel_a, sel_b;
  logic          v1_d, v1_q, s1_d, s1_q, ap1_d, ap1_q, ai1_d, ai1_q;
  spec_e         sp1_d, sp1_q;
  logic [XW-1:0] x1_d, x1_q;
  logic [PW-1:0] p1_d, p1_q;
  logic [MA-1:0] am1_d, am1_q;

  always_comb begin
    za    = (ea == '0);
    zb    = (eb == '0);
    ia    = (&ea) & ~(|ma);
    ib    = (&eb) & ~(|mb);
    na    = (&ea) & (|ma);
    nb    = (&eb) & (|mb);
    sp1_d = SP_NONE;
    if (na | nb | (ia & zb) | (ib & za)) sp1_d = SP_NAN;
    else if (ia | ib)                    sp1_d = SP_INF;
    else if (za | zb)                    sp1_d = SP_ZERO;
    v1_d  = in_valid;
    s1_d  = sa ^ sb;
    x1_d  = XW'(ea) + XW'(eb) - XW'(BIAS);
    p1_d  = PW'({1'b1, ma}) * PW'({1'b1, mb});
    sel_a = (&ma) | ~(|ma);
    sel_b = (&mb) | ~(|mb);
    ap1_d = in_mode & (sp1_d == SP_NONE) & (sel_a | sel_b);
    am1_d = sel_a ? mb : ma;
    ai1_d = sel_a ? (&ma) : (&mb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      s1_q  <= 1'b0;
      sp1_q <= SP_NONE;
      x1_q  <= '0;
      p1_q  <= '0;
      ap1_q <= 1'b0;
      am1_q <= '0;
      ai1_q <= 1'b0;
    end else if (en) begin
      v1_q  <= v1_d;
      s1_q  <= s1_d;
      sp1_q <= sp1_d;
      x1_q  <= x1_d;
      p1_q  <= p1_d;
      ap1_q <= ap1_d;
      am1_q <= am1_d;
      ai1_q <= ai1_d;
    end
  end

  // Stage 2: normalise, round to nearest even, or take the bypass mantissa
  logic          norm, g, r, st;
  logic [MA-1:0] kept;
  logic [MA:0]   rsum;
  logic          v2_d, v2_q, s2_d, s2_q, ap2_d, ap2_q;
  spec_e         sp2_d, sp2_q;
  logic [XW-1:0] x2_d, x2_q;
  logic [MA-1:0] m2_d, m2_q;

  always_comb begin
    norm  = p1_q[PW-1];
    kept  = norm ? p1_q[PW-2 -: MA] : p1_q[PW-3 -: MA];
    g     = norm ? p1_q[MA]     : p1_q[MA-1];
    r     = norm ? p1_q[MA-1]   : p1_q[MA-2];
    st    = norm ? |p1_q[MA-2:0] : |p1_q[MA-3:0];
    rsum  = {1'b0, kept} + MW'(g & (r | st | kept[0]));
    v2_d  = v1_q;
    s2_d  = s1_q;
    sp2_d = sp1_q;
    ap2_d = ap1_q;
    m2_d  = rsum[MA-1:0];
    x2_d  = x1_q + XW'(norm) + XW'(rsum[MA]);
    if (ap1_q) begin
      m2_d = am1_q;
      x2_d = x1_q + XW'(ai1_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      s2_q  <= 1'b0;
      sp2_q <= SP_NONE;
      x2_q  <= '0;
      m2_q  <= '0;
      ap2_q <= 1'b0;
    end else if (en) begin
      v2_q  <= v2_d;
      s2_q  <= s2_d;
      sp2_q <= sp2_d;
      x2_q  <= x2_d;
      m2_q  <= m2_d;
      ap2_q <= ap2_d;
    end
  end

  // Stage 3: exponent range check, special values, pack
  logic         out_valid_d, out_valid_q, out_approx_d, out_approx_q;
  logic [N-1:0] out_y_d, out_y_q;

  always_comb begin
    out_valid_d  = v2_q;
    out_approx_d = v2_q & ap2_q;
    out_y_d      = {s2_q, x2_q[E-1:0], m2_q};
    case (sp2_q)
      SP_NAN:  out_y_d = {1'b0, {E{1'b1}}, 1'b1, {(MA-1){1'b0}}};
      SP_INF:  out_y_d = {s2_q, {E{1'b1}}, {MA{1'b0}}};
      SP_ZERO: out_y_d = {s2_q, {(E+MA){1'b0}}};
      default: begin
        if (x2_q[XW-1] || (x2_q == '0))
          out_y_d = {s2_q, {(E+MA){1'b0}}};
        else if (x2_q[XW-2:0] >= (XW-1)'(EMAX))
          out_y_d = {s2_q, {E{1'b1}}, {MA{1'b0}}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
      out_approx_q <= 1'b0;
    end else if (en) begin
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      out_approx_q <= out_approx_d;
    end
  end

  // Saturating count of delivered bypass results; clear wins over increment
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (out_valid_q & out_ready & out_approx_q & ~(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_approx = out_approx_q;
  assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_cfpu_pipe.sv
// Bench for cfpu_pipe (single precision, 4-bit counter): directed cases, backpressure,
// counter saturation/clear, mid-stream reset and randomized operands vs. an arithmetic model.
module tb_cfpu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_mode;
  logic [31:0] in_a, in_b, out_y;
  logic        out_valid, out_ready, out_approx, cnt_clr;
  logic [3:0]  approx_cnt;

  cfpu_pipe #(.E(8), .MA(23), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_approx(out_approx),
    .cnt_clr(cnt_clr), .approx_cnt(approx_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    bit          ap;
    int          age;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cnt_m = 0;
  int   hold_lo = 0;
  bit   rnd_rdy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: integer significand product, remainder-vs-half rounding
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input bit mode,
                                  output logic [31:0] y, output bit ap);
    int     ea, eb, ex, sh;
    longint fa, fb, p, qq, rem, half, mant;
    bit     s, za, zb, ia, ib, na, nb;
    bit     a_sel, b_sel;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
    ap = 0;
    y  = 32'h0;
    if (na || nb || (ia && zb) || (ib && za)) y = 32'h7FC00000;
    else if (ia || ib) y = {s, 8'hFF, 23'h0};
    else if (za || zb) y = {s, 31'h0};
    else begin
      ex = ea + eb - 127;
      a_sel = (fa == 0) || (fa == 64'h7FFFFF);
      b_sel = (fb == 0) || (fb == 64'h7FFFFF);
      if (mode && a_sel) begin
        ap = 1; mant = fb; if (fa == 64'h7FFFFF) ex++;
      end else if (mode && b_sel) begin
        ap = 1; mant = fa; if (fb == 64'h7FFFFF) ex++;
      end else begin
        p  = (fa + (64'd1 << 23)) * (fb + (64'd1 << 23));
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        ex += sh - 23;
        qq   = p >> sh;
        rem  = p - (qq << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && qq[0])) qq++;
        if (qq == (64'd1 << 24)) begin qq = qq >> 1; ex++; end
        mant = qq - (64'd1 << 23);
      end
      if (ex >= 255)   y = {s, 8'hFF, 23'h0};
      else if (ex <= 0) y = {s, 31'h0};
      else             y = {s, 8'(ex), 23'(mant)};
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 7))
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'($urandom_range(1, 3));
      3: e = 8'($urandom_range(252, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    case ($urandom_range(0, 3))
      0: m = '0;
      1: m = '1;
      default: m = 23'($urandom);
    endcase
    return {1'($urandom), e, m};
  endfunction

  function automatic bit next_ordy();
    if (hold_lo > 0) begin hold_lo--; return 1'b0; end
    if (rnd_rdy) return 1'($urandom);
    return 1'b1;
  endfunction

  // One clock: drive at negedge, check outputs, then advance the expected-result queue
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b, input bit m,
                       input bit clr, input bit has_exp, input logic [31:0] ey, input bit eap,
                       output bit acc);
    bit ordy, exp_ov, stall, oh, rap;
    logic [31:0] ry;
    @(negedge clk);
    ordy = next_ordy();
    in_valid = v; in_a = a; in_b = b; in_mode = m; out_ready = ordy; cnt_clr = clr;
    #1;
    exp_ov = (q.size() > 0) && (q[0].age == 3);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("out_y", out_y, q[0].y);
      check("out_approx", 32'(out_approx), 32'(q[0].ap));
    end
    stall = exp_ov && !ordy;
    check("in_ready", 32'(in_ready), 32'(!stall));
    check("approx_cnt", 32'(approx_cnt), 32'(cnt_m));
    oh = exp_ov && ordy;
    if (clr) cnt_m = 0;
    else if (oh && q[0].ap && cnt_m != 15) cnt_m++;
    if (oh) void'(q.pop_front());
    if (!stall) foreach (q[i]) q[i].age++;
    acc = v && !stall;
    if (acc) begin
      if (has_exp) begin ry = ey; rap = eap; end
      else ref_mul(a, b, m, ry, rap);
      q.push_back('{y: ry, ap: rap, age: 1});
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit m,
                      input bit has_exp, input logic [31:0] ey, input bit eap);
    bit acc;
    int tries = 0;
    do begin
      cycle(1'b1, a, b, m, 1'b0, has_exp, ey, eap, acc);
      tries++;
    end while (!acc && tries < 64);
    if (!acc) begin
      tests++; fails++;
      $error("FAIL send_timeout: in_ready stayed low for %0d cycles", tries);
    end
  endtask

  task automatic idle(input bit clr);
    bit acc;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, clr, 1'b0, 32'h0, 1'b0, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin idle(1'b0); n++; end
    if (q.size() > 0) begin
      tests++; fails++;
      $error("FAIL drain_timeout: %0d results still pending", q.size());
    end
    idle(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_y", out_y, 32'h0);
    check("rst_out_approx", 32'(out_approx), 32'h0);
    check("rst_approx_cnt", 32'(approx_cnt), 32'h0);
    q.delete();
    cnt_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    do_reset();
    idle(1'b0);
    check("in_ready_after_reset", 32'(in_ready), 32'h1);

    // Directed values
    send(32'h3FC00000, 32'h3FC00000, 1'b0, 1'b1, 32'h40100000, 1'b0);
    drain();
    send(32'h3FFFFFFF, 32'h3FC00000, 1'b1, 1'b1, 32'h40400000, 1'b1);
    send(32'h3FFFFFFF, 32'h3FC00000, 1'b0, 1'b1, 32'h403FFFFF, 1'b0);
    send(32'h7F000000, 32'h40000000, 1'b0, 1'b1, 32'h7F800000, 1'b0);
    send(32'h00800000, 32'h3F000000, 1'b0, 1'b1, 32'h00000000, 1'b0);
    send(32'h7F800000, 32'h00000000, 1'b1, 1'b1, 32'h7FC00000, 1'b0);
    send(32'hBF800000, 32'h40000000, 1'b0, 1'b1, 32'hC0000000, 1'b0);
    drain();
    check("cnt_after_one_bypass", 32'(approx_cnt), 32'h1);

    // Backpressure: back-to-back stream with random ready and a 4-cycle low hold
    rnd_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) hold_lo = 4;
      send(rand_op(), rand_op(), 1'($urandom), 1'b0, 32'h0, 1'b0);
    end
    drain();
    rnd_rdy = 1'b0;

    // Counter saturation, then clear coinciding with a bypass handshake
    idle(1'b1);
    for (int i = 0; i < 20; i++)
      send(32'h3F800000, {1'b0, 8'($urandom_range(100, 154)), 23'($urandom)}, 1'b1,
           1'b0, 32'h0, 1'b0);
    drain();
    check("cnt_saturated", 32'(approx_cnt), 32'hF);
    send(32'h3F800000, 32'h40400000, 1'b1, 1'b1, 32'h40400000, 1'b1);
    while (q.size() > 0 && q[0].age < 3) idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    check("cnt_clr_wins", 32'(approx_cnt), 32'h0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) send(32'h3FC00000, 32'h40000000, 1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    idle(1'b0);
    idle(1'b0);
    send(32'h40000000, 32'h40400000, 1'b0, 1'b1, 32'h40C00000, 1'b0);
    drain();

    // Randomized operands and modes under random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1'b0);
      else send(rand_op(), rand_op(), 1'($urandom), 1'b0, 32'h0, 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
